ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of the single-port data RAM
//  (sync write, read data registered on posedge when we=0).
//  Shares the RAM between requester 0 (CPU) and requester 1 (loader/debug).
//  Serialises accesses, guarantees one-cycle RAM setup, returns read data with a valid pulse,
//  and blocks out-of-range addresses before they reach the RAM.
// PARAMETERS
//  DEPTH  10000  number of RAM words; legal addr 0..DEPTH-1
//  AW     32     address width
//  DW     32     data width
// PORTS
//  clk       in   1      system clock, all logic on posedge
//  rst       in   1      asynchronous reset, active-high
//  req       in   2      access request per requester, [0]=CPU [1]=loader
//  req_we    in   2      1=write 0=read, per requester, valid while req high
//  req_addr  in   2*AW   {addr1,addr0}
//  req_wd    in   2*DW   {wd1,wd0} write data
//  ack       out  2      one-cycle pulse: access accepted/issued for requester i
//  err       out  2      one-cycle pulse with ack: addr >= DEPTH, access dropped
//  rvalid    out  2      one-cycle pulse: rdata holds read result for requester i
//  rdata     out  DW     read data, valid when any rvalid bit is high
//  busy      out  1      state != IDLE
//  mem_we    out  1      RAM write enable
//  mem_addr  out  AW     RAM address
//  mem_wd    out  DW     RAM write data
//  mem_rd    in   DW     RAM read data (valid the cycle after address presented with we=0)
// BEHAVIOUR
//  Reset (async): state=IDLE, last_grant=1 (so req 0 wins first contention); ack, err, rvalid,
//   busy, mem_we=0; mem_addr, mem_wd, rdata=0; latched we/addr/wd/grant=0.
//  FSM states IDLE, ACCESS, RESP.
//  IDLE: req sampled. If req==0, stay. One bit set: grant it. Both set: grant !last_grant.
//   On grant: latch we, addr, wd and grant id, update last_grant, go ACCESS.
//  ACCESS (1 cycle): ack[g]=1. mem_addr=latched addr, mem_wd=latched wd.
//   In range + write: mem_we=1, next IDLE.
//   In range + read: mem_we=0, next RESP.
//   Out of range (addr>=DEPTH): err[g]=1 with ack[g], mem_we=0, next IDLE, rdata unchanged.
//  RESP (1 cycle): mem_we=0, mem_addr held. At end of cycle rdata<=mem_rd and rvalid[g]<=1.
//   Next IDLE.
//  rvalid is a registered pulse, high exactly one cycle (the cycle after RESP).
//   rdata holds its value until the next read completes.
//  mem_we, ack, err, busy are decoded from state/latched flops only; no path from req inputs.
//   mem_we drops combinationally when rst asserts.
//  Handshake: requester holds req/we/addr/wd stable until it sees ack.
//   req high in the first IDLE cycle after ack is a new request.
//   Inputs outside IDLE are ignored.
//  Timing, from the req-sampled IDLE cycle t:
//   write: ack at t+1, RAM written at end of t+1, back in IDLE at t+2.
//   read: ack at t+1, RESP t+2, rvalid/rdata at t+3 (same cycle as next IDLE).
//  Throughput: write 2 cycles, read 3 cycles per access.
//   Under continuous contention grants strictly alternate; max wait for the losing
//   requester is one access.
//  Simultaneous rvalid of the previous read and a new grant in IDLE is legal; both happen.
//  Reset mid-operation: the in-flight access is abandoned.
//   A write in ACCESS is not performed (mem_we forced 0).
//   A pending read yields no rvalid. No ack/err/rvalid after reset release until a new grant.
// TESTING
//  T1 reset: rst=1 for 3 cycles mid-traffic -> all outputs 0, busy=0, mem_we=0;
//     first grant after release goes to req 0.
//  T2 write/read: req0 write addr 5 wd 0xDEADBEEF -> ack[0] at t+1, mem_we=1 one cycle.
//     Then req0 read addr 5 -> ack[0] at t+1, rvalid[0] at t+3, rdata=0xDEADBEEF.
//  T3 contention: req=2'b11, both reads, held for 4 accesses -> grant order 0,1,0,1;
//     each rvalid on the matching bit with the correct data.
//  T4 out of range: req1 write addr 10000 wd 0x12345678 -> ack[1]&err[1] same cycle,
//     mem_we never 1; read of addr 9999 returns its prior value.
//  T5 reset in ACCESS: rst asserted during write ACCESS to addr 7 -> mem_we low immediately,
//     addr 7 unchanged, state IDLE.
//  T6 streaming: req0 reads addr 0..3 back-to-back, req1 idle -> ack[0] every 3 cycles,
//     rvalid[0] every 3 cycles, data in order.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_arbiter_if
//  Bundles the requester-side handshake and the RAM-side bus of ram_arbiter.
//
//  Requester side
//    req       [1:0]       access request, [0]=CPU [1]=loader
//    req_we    [1:0]       1=write 0=read, valid while req high
//    req_addr  [2*AW-1:0]  {addr1, addr0}
//    req_wd    [2*DW-1:0]  {wd1, wd0}
//    ack       [1:0]       one-cycle pulse, access accepted for requester i
//    err       [1:0]       one-cycle pulse with ack, address out of range
//    rvalid    [1:0]       one-cycle pulse, rdata holds read result for i
//    rdata     [DW-1:0]    read data
//    busy                  arbiter not idle
//  RAM side
//    mem_we                RAM write enable
//    mem_addr  [AW-1:0]    RAM address
//    mem_wd    [DW-1:0]    RAM write data
//    mem_rd    [DW-1:0]    RAM read data (registered by the RAM)
//
//  Modports: slave = the arbiter, master = requesters plus the RAM.
// ----------------------------------------------------------------------------
interface ram_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [1:0]      req;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wd;
    logic [1:0]      ack;
    logic [1:0]      err;
    logic [1:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wd;
    logic [DW-1:0]   mem_rd;

    modport slave (
        input  req, req_we, req_addr, req_wd, mem_rd,
        output ack, err, rvalid, rdata, busy, mem_we, mem_addr, mem_wd
    );

    modport master (
        output req, req_we, req_addr, req_wd, mem_rd,
        input  ack, err, rvalid, rdata, busy, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//  Two-port round-robin arbiter/sequencer in front of a single-port data RAM
//  (synchronous write, read data registered by the RAM when we=0).
//  Requester 0 is the CPU, requester 1 the loader/debug port. Accesses are
//  serialised: IDLE -> ACCESS -> (RESP for reads) -> IDLE. Out-of-range
//  addresses (>= DEPTH) are acknowledged with err and never write the RAM.
//
//  Ports
//    clk   system clock, all logic on posedge
//    rst   asynchronous reset, active-high
//    bus   ram_arbiter_if.slave (requester handshake and RAM bus)
//
//  Parameters
//    DEPTH number of RAM words, legal addresses 0..DEPTH-1
//    AW    address width
//    DW    data width
// ----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int unsigned DEPTH = 10000,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          oor_q, oor_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          sel;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wd;
    logic          sel_we;
    logic          in_access;
    logic [1:0]    grant_oh;

    // Round-robin pick; only meaningful when at least one req bit is set.
    always_comb begin
        sel = 1'b0;
        case (bus.req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_grant_q;
            default: sel = 1'b0;
        endcase
    end

    assign sel_addr = sel ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
    assign sel_wd   = sel ? bus.req_wd[2*DW-1:DW]   : bus.req_wd[DW-1:0];
    assign sel_we   = sel ? bus.req_we[1]           : bus.req_we[0];

    // Next-state logic. Request inputs are only looked at in IDLE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wd_d         = wd_q;
        oor_d        = oor_q;

        case (state_q)
            StIdle: begin
                if (bus.req != 2'b00) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    we_d         = sel_we;
                    addr_d       = sel_addr;
                    wd_d         = sel_wd;
                    // Range check done at latch time so ACCESS decodes from a flop.
                    oor_d        = (sel_addr >= AW'(DEPTH));
                    state_d      = StAccess;
                end
            end
            StAccess: begin
                state_d = (oor_q || we_q) ? StIdle : StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign in_access = (state_q == StAccess);
    assign grant_oh  = grant_q ? 2'b10 : 2'b01;

    // The RAM registers read data at the end of ACCESS, so mem_rd is valid
    // during RESP and is captured here at the end of RESP.
    always_comb begin
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        if (state_q == StResp) begin
            rvalid_d = grant_oh;
            rdata_d  = bus.mem_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wd_q         <= '0;
            oor_q        <= 1'b0;
            rvalid_q     <= 2'b00;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            oor_q        <= oor_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    // Outputs decode from flops only; no combinational path from req.
    assign bus.ack      = in_access ? grant_oh : 2'b00;
    assign bus.err      = (in_access && oor_q) ? grant_oh : 2'b00;
    // rst gates mem_we directly so an in-flight write is dropped at once.
    assign bus.mem_we   = in_access && we_q && !oor_q && !rst;
    assign bus.busy     = (state_q != StIdle);
    assign bus.mem_addr = addr_q;
    assign bus.mem_wd   = wd_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    localparam int unsigned DEPTH = 10000;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;

    logic clk;
    logic rst;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: sync write, registered read when we=0.
    logic [DW-1:0] ram [0:DEPTH-1];
    logic [DW-1:0] ram_rd_q;
    int            bad_we = 0;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            if (bus.mem_addr < DEPTH) ram[bus.mem_addr] <= bus.mem_wd;
            else bad_we <= bad_we + 1;
        end else if (bus.mem_addr < DEPTH) begin
            ram_rd_q <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rd = ram_rd_q;

    int n_vec = 0;
    int n_bad = 0;
    logic [DW-1:0] last_rd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        check({name, ".ack"},    64'(bus.ack),    64'(0));
        check({name, ".err"},    64'(bus.err),    64'(0));
        check({name, ".rvalid"}, 64'(bus.rvalid), 64'(0));
        check({name, ".busy"},   64'(bus.busy),   64'(0));
        check({name, ".mem_we"}, 64'(bus.mem_we), 64'(0));
    endtask

    typedef struct {
        int            id;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        bit            exp_err;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl [12];

    // One single-requester access starting in IDLE; ends in the next IDLE cycle.
    task automatic do_access(input vec_t v);
        logic [1:0] oh;
        oh = (v.id == 1) ? 2'b10 : 2'b01;
        bus.req_we[v.id]              = v.we;
        bus.req_addr[v.id*AW +: AW]   = v.addr;
        bus.req_wd[v.id*DW +: DW]     = v.wd;
        bus.req[v.id]                 = 1'b1;
        step();
        check("acc.ack",  64'(bus.ack),  64'(oh));
        check("acc.err",  64'(bus.err),  v.exp_err ? 64'(oh) : 64'(0));
        check("acc.busy", 64'(bus.busy), 64'(1));
        check("acc.mem_we", 64'(bus.mem_we), 64'(v.we && !v.exp_err));
        if (!v.exp_err) check("acc.mem_addr", 64'(bus.mem_addr), 64'(v.addr));
        bus.req[v.id] = 1'b0;
        if (v.we || v.exp_err) begin
            step();
            check("done.busy",   64'(bus.busy),   64'(0));
            check("done.mem_we", 64'(bus.mem_we), 64'(0));
            check("done.rvalid", 64'(bus.rvalid), 64'(0));
            if (v.exp_err) check("err.rdata_held", 64'(bus.rdata), 64'(last_rd));
            else           check("ram.written", 64'(ram[v.addr]), 64'(v.wd));
        end else begin
            step();
            check("resp.mem_we", 64'(bus.mem_we), 64'(0));
            check("resp.rvalid", 64'(bus.rvalid), 64'(0));
            step();
            check("rd.rvalid", 64'(bus.rvalid), 64'(oh));
            check("rd.rdata",  64'(bus.rdata),  64'(v.exp_rd));
            last_rd = v.exp_rd;
        end
    endtask

    initial begin
        tbl[0]  = '{0, 1'b1, 32'd5,     32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{0, 1'b0, 32'd5,     32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1, 1'b1, 32'd9999,  32'hA5A5A5A5, 1'b0, 32'h0};
        tbl[3]  = '{1, 1'b1, 32'd10000, 32'h12345678, 1'b1, 32'h0};
        tbl[4]  = '{0, 1'b0, 32'd9999,  32'h0,        1'b0, 32'hA5A5A5A5};
        tbl[5]  = '{1, 1'b1, 32'd0,     32'h11111111, 1'b0, 32'h0};
        tbl[6]  = '{1, 1'b1, 32'd1,     32'h22222222, 1'b0, 32'h0};
        tbl[7]  = '{0, 1'b1, 32'd2,     32'h33333333, 1'b0, 32'h0};
        tbl[8]  = '{1, 1'b1, 32'd3,     32'h44444444, 1'b0, 32'h0};
        tbl[9]  = '{0, 1'b1, 32'd7,     32'h77777777, 1'b0, 32'h0};
        tbl[10] = '{1, 1'b0, 32'd0,     32'h0,        1'b0, 32'h11111111};
        tbl[11] = '{0, 1'b0, 32'hFFFFFFFF, 32'h0,     1'b1, 32'h0};

        rst          = 1'b1;
        bus.req      = 2'b00;
        bus.req_we   = 2'b00;
        bus.req_addr = '0;
        bus.req_wd   = '0;
        step();
        step();
        check_quiet("reset");
        check("reset.rdata",    64'(bus.rdata),    64'(0));
        check("reset.mem_addr", 64'(bus.mem_addr), 64'(0));
        check("reset.mem_wd",   64'(bus.mem_wd),   64'(0));
        rst = 1'b0;
        step();
        check_quiet("idle");

        foreach (tbl[i]) do_access(tbl[i]);

        // Streaming reads by requester 0: ack and rvalid every 3 cycles.
        bus.req_we[0]       = 1'b0;
        bus.req_addr[AW-1:0] = 32'd0;
        bus.req[0]          = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] exp_d;
            exp_d = 32'h11111111 * DW'(i + 1);
            step();
            check("stream.ack", 64'(bus.ack), 64'(2'b01));
            if (i == 3) bus.req[0] = 1'b0;
            step();
            check("stream.resp_rvalid", 64'(bus.rvalid), 64'(0));
            step();
            check("stream.rvalid", 64'(bus.rvalid), 64'(2'b01));
            check("stream.rdata",  64'(bus.rdata),  64'(exp_d));
            bus.req_addr[AW-1:0] = AW'(i + 1);
        end

        // Reset asserted during a write ACCESS: write must not happen.
        bus.req_we[0]        = 1'b1;
        bus.req_addr[AW-1:0] = 32'd7;
        bus.req_wd[DW-1:0]   = 32'hCAFEF00D;
        bus.req[0]           = 1'b1;
        step();
        check("rstacc.mem_we_before", 64'(bus.mem_we), 64'(1));
        rst        = 1'b1;
        bus.req[0] = 1'b0;
        #1;
        check_quiet("rstacc.immediate");
        for (int i = 0; i < 3; i++) step();
        check_quiet("rstacc.held");
        check("rstacc.rdata", 64'(bus.rdata), 64'(0));
        rst = 1'b0;
        step();
        check("rstacc.ram7", 64'(ram[7]), 64'(32'h77777777));
        check_quiet("rstacc.after");

        // Reset while a read is in RESP: no rvalid may follow.
        bus.req_we[1]           = 1'b0;
        bus.req_addr[2*AW-1:AW] = 32'd0;
        bus.req[1]              = 1'b1;
        step();
        check("rstrd.ack", 64'(bus.ack), 64'(2'b10));
        bus.req[1] = 1'b0;
        step();
        check("rstrd.busy", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        step();
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("rstrd.after");
        end

        // Contention right after reset: grants alternate starting with 0.
        bus.req_we              = 2'b00;
        bus.req_addr[AW-1:0]    = 32'd2;
        bus.req_addr[2*AW-1:AW] = 32'd3;
        bus.req                 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] oh;
            oh = k[0] ? 2'b10 : 2'b01;
            step();
            check("cont.ack", 64'(bus.ack), 64'(oh));
            if (k == 3) bus.req = 2'b00;
            step();
            step();
            check("cont.rvalid", 64'(bus.rvalid), 64'(oh));
            check("cont.rdata",  64'(bus.rdata),  k[0] ? 64'(32'h44444444) : 64'(32'h33333333));
        end
        step();
        check_quiet("cont.end");

        check("oor.never_written", 64'(bad_we), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
